// File: rtl/imem_responder_pkg.sv
// rtl/imem_responder_pkg.sv - rv32i shared types: word, NOP encoding, responder FSM states
package rv32i_types;

  typedef logic [31:0] rv32i_word;

  // addi x0,x0,0
  localparam rv32i_word RV32I_NOP = 32'h0000_0013;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } imem_state_t;

endpackage

// File: rtl/imem_responder_if.sv
// rtl/imem_responder_if.sv - rv32i instruction fetch port between core and memory responder
interface imem_responder_if;
  import rv32i_types::*;

  logic      inst_read;
  rv32i_word inst_addr;
  rv32i_word inst_rdata;
  logic      inst_resp;
  logic      fetch_err;

  // core side issues fetches
  modport master (
    output inst_read, inst_addr,
    input  inst_rdata, inst_resp, fetch_err
  );

  // memory side answers them
  modport slave (
    input  inst_read, inst_addr,
    output inst_rdata, inst_resp, fetch_err
  );

endinterface

// File: rtl/imem_store.sv
// rtl/imem_store.sv - DEPTHx32 program store, synchronous write, combinational read-before-write
module imem_store
  import rv32i_types::*;
#(
  parameter int  DEPTH = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] widx,
  input  rv32i_word     wdata,
  input  logic [AW-1:0] ridx,
  output rv32i_word     rdata
);

  rv32i_word mem [DEPTH];

  // contents survive reset; a write lands at the edge, so a same-edge read sees the old word
  always_ff @(posedge clk) begin
    if (we) begin
      mem[widx] <= wdata;
    end
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - loadable instruction memory answering fetches after a fixed latency
module imem_responder
  import rv32i_types::*;
#(
  parameter int        DEPTH     = 256,
  parameter rv32i_word BASE_ADDR = 32'h0000_0000,
  parameter int        LATENCY   = 1,
  parameter rv32i_word NOP_WORD  = RV32I_NOP,
  localparam int       AW        = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  imem_responder_if.slave bus,
  input  logic            load_en,
  input  logic [AW-1:0]   load_idx,
  input  rv32i_word       load_data,
  output rv32i_word       req_count
);

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  imem_state_t state;
  logic [3:0]  cnt;
  rv32i_word   pend_word;
  logic        pend_err;

  rv32i_word   off;
  rv32i_word   store_word;
  logic        misaligned;
  logic        out_of_range;
  logic        bad_fetch;
  logic        respond;
  logic        accept;

  // offset wraps modulo 2^32, so addresses below BASE_ADDR land far out of range
  assign off          = bus.inst_addr - BASE_ADDR;
  assign misaligned   = |off[1:0];
  assign out_of_range = (off[31:2] >= 30'(DEPTH));
  assign bad_fetch    = misaligned | out_of_range;

  // response cycle doubles as the only accept slot while busy
  assign respond = (state == WAIT) && (cnt == 4'd0);
  assign accept  = bus.inst_read && ((state == IDLE) || respond);

  imem_store #(
    .DEPTH (DEPTH)
  ) u_store (
    .clk   (clk),
    .we    (load_en & ~rst),
    .widx  (load_idx),
    .wdata (load_data),
    .ridx  (off[2 +: AW]),
    .rdata (store_word)
  );

  // fetch FSM: latch word at accept, count down, pulse the response, count accepts
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= 4'd0;
      pend_word      <= '0;
      pend_err       <= 1'b0;
      bus.inst_resp  <= 1'b0;
      bus.inst_rdata <= '0;
      bus.fetch_err  <= 1'b0;
      req_count      <= '0;
    end else begin
      bus.inst_resp <= respond;
      if (respond) begin
        bus.inst_rdata <= pend_word;
        bus.fetch_err  <= pend_err;
      end
      if (accept) begin
        pend_word <= bad_fetch ? NOP_WORD : store_word;
        pend_err  <= bad_fetch;
        cnt       <= CNT_INIT;
        state     <= WAIT;
        req_count <= req_count + 32'd1;
      end else if (respond) begin
        state <= IDLE;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Parametrised instruction-memory responder for the rv32i core's imem port (inst_read/inst_addr/inst_rdata/inst_resp).
- Replaces hand-driven instruction words with a loadable program store.
- Adds configurable response latency, base address, out-of-range and misalignment handling, and a request counter.
- Sits between one_hz_cpu's imem port and the bench, or an FPGA boot-loader, which fills it through the load port.

Parameters:
- DEPTH, 256, number of 32-bit instruction words; power of two, ≥ 2
- BASE_ADDR, 32'h0000_0000, byte address of word index 0; 4-byte aligned
- LATENCY, 1, cycles from request accept to inst_resp; legal range 1..15
- NOP_WORD, 32'h0000_0013, word returned for out-of-range or misaligned fetches (addi x0,x0,0)

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- inst_read  in  1  fetch request from core
- inst_addr  in  32  fetch byte address, sampled at accept
- inst_rdata  out  32  fetched word, valid only while inst_resp=1
- inst_resp  out  1  one-cycle response pulse
- load_en  in  1  write one word into the store
- load_idx  in  $clog2(DEPTH)  word index to write
- load_data  in  32  word to write
- fetch_err  out  1  pulses with inst_resp when the fetch was out-of-range or misaligned
- req_count  out  32  number of accepted fetches since reset; wraps 0xFFFF_FFFF -> 0

Behaviour:
- Reset values:
  - inst_resp=0, inst_rdata=0, fetch_err=0, req_count=0, state=IDLE, latency counter=0.
  - Store contents are NOT cleared by reset.
- FSM states: IDLE, WAIT.
  - IDLE + inst_read=1: accept the request. Latch the word (or NOP_WORD) and the error flag, load cnt=LATENCY-1, then go to WAIT.
  - WAIT with cnt>0: decrement cnt.
  - WAIT with cnt=0: assert inst_resp=1 for that cycle.
    - If inst_read=1 in the same cycle, accept the new request (back-to-back) and stay in WAIT with cnt=LATENCY-1.
    - Otherwise go to IDLE.
- Latency: inst_resp is high exactly LATENCY cycles after the accept edge.
  - LATENCY=1 gives one fetch per cycle under continuous inst_read.
- inst_read in WAIT while cnt>0: ignored. The core must hold it, and it is accepted at the response cycle.
- Address decode:
  - off = inst_addr - BASE_ADDR (32-bit, modulo 2^32).
  - Misaligned: inst_addr[1:0] != 0.
  - Out of range: off[31:2] >= DEPTH.
  - Either condition: word = NOP_WORD, fetch_err=1 at the response.
  - Otherwise: word = store[off[2+:$clog2(DEPTH)]].
- Read sampling: the word is read at the accept edge.
  - load_en to the same index in the accept cycle: the read returns the old contents (read-before-write).
  - A later load does not alter an in-flight response.
- Load port:
  - Writes take effect at the edge, in any state.
  - load_en during rst is ignored.
- inst_rdata and fetch_err hold their last values between responses. Consumers qualify them with inst_resp.
- req_count increments on every accept edge.
- Reset mid-request:
  - The in-flight fetch is dropped and no inst_resp is issued.
  - inst_read held high across reset release is accepted on the first cycle with rst=0.

Decomposition:
- Shared package rv32i_types:
  - rv32i_word (32-bit) typedef.
  - Constant RV32I_NOP = 32'h0000_0013, used as the NOP_WORD default.
  - Enum imem_state_t {IDLE, WAIT}.
- One sub-module, imem_store: DEPTH×32 synchronous-write array with a combinational read port and read-before-write semantics. The FSM, decode and counter stay in imem_responder.

Test Plan:
1. Reset, then load idx0..3 = 0x00F00093, 0x01F00113, 0x03F00193, 0x07F00213. With LATENCY=1 and inst_read held high, fetch addrs 0,4,8,12 -> inst_resp high on 4 consecutive cycles returning those words in order, fetch_err=0, req_count=4.
2. LATENCY=3, single fetch of addr 4 -> inst_resp exactly 3 cycles after accept with 0x01F00113; inst_read held through WAIT causes a second accept only on the response cycle.
3. DEPTH=256, BASE=0: fetch addr 0x400 -> 0x00000013 with fetch_err=1. Fetch addr 0x6 -> 0x00000013 with fetch_err=1. BASE=0x60, fetch 0x5C -> wraps to huge offset, so out of range with fetch_err=1.
4. Accept fetch of idx 2 in the same cycle as load_en idx2=0x002080B3 -> response returns the old word 0x03F00193. The next fetch of addr 8 returns 0x002080B3.
5. LATENCY=4: accept, assert rst after 2 cycles -> no inst_resp ever, outputs 0, req_count=0. Store still returns the previously loaded words after release.
6. Force req_count to 0xFFFF_FFFF (hierarchical deposit), issue one fetch -> req_count=0.
